// File: rtl/frame_parity_pkg.sv
// Shared types and defaults for the frame parity accumulator.
package frame_parity_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int unsigned FRAME_LEN_MAX    = 255;
   localparam logic        ODD_INIT_DEFAULT = 1'b0;

endpackage

// File: rtl/frame_parity_term.sv
// Reduces one 3-bit symbol to its XNOR3 parity term.
module frame_parity_term (
   input  logic a1,
   input  logic a2,
   input  logic a3,
   output logic t
);

   assign t = ~(a1 ^ a2 ^ a3);

endmodule

// File: rtl/frame_parity_acc.sv
// Streaming XNOR3-term parity accumulator with a valid/ready frame-parity output.
// Optional build macro FRAME_PARITY_CHECK_EN adds the CHK_PAR compare and PAR_ERR pulse.
module frame_parity_acc
   import frame_parity_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned CNT_W     = 8,
   parameter logic        ODD_INIT  = ODD_INIT_DEFAULT
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             A1,
   input  logic             A2,
   input  logic             A3,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             FLUSH,
   output logic             PAR,
   output logic             PAR_VALID,
   input  logic             PAR_READY,
   output logic             FLUSHED,
   output logic [CNT_W-1:0] CNT
`ifdef FRAME_PARITY_CHECK_EN
   ,
   input  logic             CHK_PAR,
   output logic             PAR_ERR
`endif
);

   // Handshakes: a transfer happens on a rising CLK edge where valid and ready
   // are both 1; valid never waits on ready, and PAR/FLUSHED hold while PAR_VALID
   // is 1 and PAR_READY is 0.

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   state_e           state_q, state_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             par_valid_q, par_valid_d;
   logic             flushed_q, flushed_d;

   logic             t;
   logic             in_ready;
   logic             accept;
   logic             base_acc;
   logic [CNT_W-1:0] base_cnt;
   logic             sum;
   logic             last;
   logic             flush_close;
   logic             close;

   frame_parity_term u_term (
      .a1 (A1),
      .a2 (A2),
      .a3 (A3),
      .t  (t)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      par_d       = par_q;
      par_valid_d = par_valid_q;
      flushed_d   = flushed_q;

      in_ready = (state_q == ACC) | PAR_READY;
      accept   = IN_VALID & in_ready;

      // In HOLD the accumulator is already reseeded, so an accepted symbol opens a new frame.
      base_acc    = (state_q == HOLD) ? ODD_INIT : acc_q;
      base_cnt    = (state_q == HOLD) ? '0 : cnt_q;
      sum         = base_acc ^ (accept & t);
      last        = accept && (base_cnt == LAST_CNT);
      flush_close = FLUSH && in_ready && (accept || (base_cnt != '0));
      close       = last || flush_close;

      if (accept) begin
         acc_d = sum;
         cnt_d = base_cnt + CNT_W'(1);
      end

      case (state_q)
         ACC: ;
         HOLD: begin
            if (PAR_READY) begin
               par_valid_d = 1'b0;
               state_d     = ACC;
            end
         end
         default: state_d = ACC;
      endcase

      // A full frame takes precedence over a FLUSH on its last symbol.
      if (close) begin
         par_d       = sum;
         flushed_d   = ~last;
         par_valid_d = 1'b1;
         acc_d       = ODD_INIT;
         cnt_d       = '0;
         state_d     = HOLD;
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q     <= ACC;
         acc_q       <= ODD_INIT;
         cnt_q       <= '0;
         par_q       <= 1'b0;
         par_valid_q <= 1'b0;
         flushed_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         par_q       <= par_d;
         par_valid_q <= par_valid_d;
         flushed_q   <= flushed_d;
      end
   end

`ifdef FRAME_PARITY_CHECK_EN
   logic par_err_q, par_err_d;

   always_comb begin
      par_err_d = par_valid_q & PAR_READY & (par_q != CHK_PAR);
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign PAR_ERR = par_err_q;
`endif

   assign IN_READY  = in_ready;
   assign PAR       = par_q;
   assign PAR_VALID = par_valid_q;
   assign FLUSHED   = flushed_q;
   assign CNT       = cnt_q;

endmodule

// File: tb/tb_frame_parity_acc.sv
// Self-checking bench for frame_parity_acc (FRAME_LEN=4) against a frame-level reference model.
module tb_frame_parity_acc;

   localparam int   FL  = 4;
   localparam int   CW  = 8;
   localparam logic ODD = 1'b0;

   // clock / reset
   logic CLK = 1'b0;
   logic RN  = 1'b0;
   always #5 CLK = ~CLK;

   logic          A1 = 1'b0, A2 = 1'b0, A3 = 1'b0;
   logic          IN_VALID = 1'b0, FLUSH = 1'b0, PAR_READY = 1'b0;
   logic          IN_READY, PAR, PAR_VALID, FLUSHED;
   logic [CW-1:0] CNT;
   logic          chk_par = 1'b0;
`ifdef FRAME_PARITY_CHECK_EN
   logic          PAR_ERR;
`endif

   frame_parity_acc #(.FRAME_LEN(FL), .CNT_W(CW), .ODD_INIT(ODD)) dut (
      .CLK       (CLK),
      .RN        (RN),
      .A1        (A1),
      .A2        (A2),
      .A3        (A3),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .FLUSH     (FLUSH),
      .PAR       (PAR),
      .PAR_VALID (PAR_VALID),
      .PAR_READY (PAR_READY),
      .FLUSHED   (FLUSHED),
      .CNT       (CNT)
`ifdef FRAME_PARITY_CHECK_EN
      ,
      .CHK_PAR   (chk_par),
      .PAR_ERR   (PAR_ERR)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model: terms of the open frame plus the presented output
   bit   m_terms[$];
   logic m_par, m_pvalid, m_flushed, m_err;
   logic obs_ready, exp_ready;

   function automatic logic frame_xor();
      logic r = ODD;
      foreach (m_terms[i]) r ^= m_terms[i];
      return r;
   endfunction

   function automatic logic [CW+2:0] exp_vec();
      return {m_pvalid, m_par, m_flushed, CW'(m_terms.size())};
   endfunction

   task automatic model_reset();
      m_terms.delete();
      m_par = 1'b0; m_pvalid = 1'b0; m_flushed = 1'b0; m_err = 1'b0;
   endtask

   // driver: apply one cycle of inputs, sample IN_READY, advance the model at the edge
   task automatic cycle(input logic [2:0] sym, input logic v, input logic f, input logic pr);
      bit acc_ok, hs, full;
      {A3, A2, A1} = sym;
      IN_VALID = v; FLUSH = f; PAR_READY = pr;
      #1;
      obs_ready = IN_READY;
      exp_ready = !m_pvalid || pr;
      @(posedge CLK);
      acc_ok = v && exp_ready;
      hs     = m_pvalid && pr;
      m_err  = hs && (m_par != chk_par);
      if (acc_ok) m_terms.push_back(~^sym);
      full = acc_ok && (m_terms.size() == FL);
      if (full || (f && m_terms.size() > 0)) begin
         m_par = frame_xor(); m_flushed = !full; m_pvalid = 1'b1; m_terms.delete();
      end else if (hs) begin
         m_pvalid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      RN = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      n_vec++;
      if ({PAR_VALID, PAR, FLUSHED, CNT, IN_READY} !== {3'b000, CW'(0), 1'b1}) begin
         n_err++;
         $display("FAIL reset_state got pv=%b par=%b fl=%b cnt=%0d rdy=%b want 0 0 0 0 1",
                  PAR_VALID, PAR, FLUSHED, CNT, IN_READY);
      end
      RN = 1'b1;
      @(posedge CLK);
      #1;
      n_vec++;
      if ({PAR_VALID, CNT} !== {1'b0, CW'(0)}) begin
         n_err++; $display("FAIL reset_release got pv=%b cnt=%0d want 0 0", PAR_VALID, CNT);
      end
   endtask

   task automatic test_full_frame();
      for (int i = 0; i < FL; i++) begin
         cycle(3'b000, 1'b1, 1'b0, 1'b1);
         n_vec++;
         if ({PAR_VALID, PAR, FLUSHED, CNT} !== exp_vec() || obs_ready !== exp_ready) begin
            n_err++;
            $display("FAIL full_frame[%0d] got %b rdy=%b want %b rdy=%b", i,
                     {PAR_VALID, PAR, FLUSHED, CNT}, obs_ready, exp_vec(), exp_ready);
         end
      end
      n_vec++;
      if ({PAR_VALID, PAR, FLUSHED} !== 3'b100) begin
         n_err++; $display("FAIL full_frame_out got pv/par/fl=%b want 100", {PAR_VALID, PAR, FLUSHED});
      end
      cycle(3'b000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_mixed();
      logic [2:0] syms [8] = '{3'b000, 3'b111, 3'b111, 3'b110, 3'b000, 3'b111, 3'b100, 3'b100};
      logic       want [2] = '{1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         cycle(syms[i], 1'b1, 1'b0, 1'b1);
         n_vec++;
         if ({PAR_VALID, PAR, FLUSHED, CNT} !== exp_vec() || obs_ready !== exp_ready) begin
            n_err++;
            $display("FAIL mixed[%0d] got %b rdy=%b want %b rdy=%b", i,
                     {PAR_VALID, PAR, FLUSHED, CNT}, obs_ready, exp_vec(), exp_ready);
         end
         if (i % 4 == 3) begin
            n_vec++;
            if ({PAR_VALID, PAR} !== {1'b1, want[i/4]}) begin
               n_err++;
               $display("FAIL mixed_par[%0d] got pv=%b par=%b want 1 %b", i/4, PAR_VALID, PAR, want[i/4]);
            end
         end
      end
      cycle(3'b000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < FL; i++) cycle(3'b111, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(3'b000, 1'b1, 1'b0, 1'b0);
         n_vec++;
         if (obs_ready !== 1'b0 || {PAR_VALID, PAR, FLUSHED, CNT} !== {3'b100, CW'(0)}) begin
            n_err++;
            $display("FAIL backpressure[%0d] got rdy=%b %b want rdy=0 %b", i,
                     obs_ready, {PAR_VALID, PAR, FLUSHED, CNT}, {3'b100, CW'(0)});
         end
      end
      cycle(3'b000, 1'b1, 1'b0, 1'b1);
      n_vec++;
      if (obs_ready !== 1'b1 || CNT !== CW'(1) || PAR_VALID !== 1'b0 || CNT !== CW'(m_terms.size())) begin
         n_err++;
         $display("FAIL bp_release got rdy=%b cnt=%0d pv=%b want 1 1 0", obs_ready, CNT, PAR_VALID);
      end
      for (int i = 1; i < FL; i++) cycle(3'b000, 1'b1, 1'b0, 1'b1);
      cycle(3'b000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_flush();
      cycle(3'b000, 1'b1, 1'b0, 1'b1);
      cycle(3'b000, 1'b1, 1'b0, 1'b1);
      cycle(3'b000, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({PAR_VALID, PAR, FLUSHED, CNT} !== {3'b101, CW'(0)} || exp_vec() !== {3'b101, CW'(0)}) begin
         n_err++;
         $display("FAIL flush_out got %b want %b", {PAR_VALID, PAR, FLUSHED, CNT}, {3'b101, CW'(0)});
      end
      cycle(3'b000, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if ({PAR_VALID, CNT} !== {1'b0, CW'(0)}) begin
         n_err++; $display("FAIL flush_idle got pv=%b cnt=%0d want 0 0", PAR_VALID, CNT);
      end
      for (int i = 0; i < FL; i++) begin
         cycle(3'b000, 1'b1, 1'b0, 1'b1);
         n_vec++;
         if ({PAR_VALID, PAR, FLUSHED, CNT} !== exp_vec()) begin
            n_err++;
            $display("FAIL flush_next[%0d] got %b want %b", i, {PAR_VALID, PAR, FLUSHED, CNT}, exp_vec());
         end
      end
      n_vec++;
      if ({PAR_VALID, FLUSHED} !== 2'b10) begin
         n_err++; $display("FAIL flush_next_close got pv/fl=%b want 10", {PAR_VALID, FLUSHED});
      end
      cycle(3'b000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      int pv_cnt = 0;
      int bubbles = 0;
      for (int i = 0; i < 2 * FL + 2; i++) begin
         cycle(3'b000, (i < 2 * FL) ? 1'b1 : 1'b0, 1'b0, 1'b1);
         if (PAR_VALID === 1'b1) pv_cnt++;
         if (obs_ready !== 1'b1) bubbles++;
      end
      n_vec++;
      if (pv_cnt != 2 || bubbles != 0) begin
         n_err++; $display("FAIL back_to_back got pv_cycles=%0d bubbles=%0d want 2 0", pv_cnt, bubbles);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 3; i++) cycle(3'b000, 1'b1, 1'b0, 1'b1);
      #1 RN = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if ({PAR_VALID, CNT} !== {1'b0, CW'(0)}) begin
         n_err++; $display("FAIL reset_mid got pv=%b cnt=%0d want 0 0", PAR_VALID, CNT);
      end
      @(posedge CLK);
      #1 RN = 1'b1;
      for (int i = 0; i < FL; i++) begin
         cycle(3'b000, 1'b1, 1'b0, 1'b1);
         n_vec++;
         if (PAR_VALID !== ((i == FL - 1) ? 1'b1 : 1'b0) || {PAR_VALID, PAR, FLUSHED, CNT} !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_refill[%0d] got %b want %b", i, {PAR_VALID, PAR, FLUSHED, CNT}, exp_vec());
         end
      end
      cycle(3'b000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [2:0] sym;
      logic       v, f, pr;
      for (int i = 0; i < 400; i++) begin
         sym = 3'($urandom_range(0, 7));
         v   = ($urandom_range(0, 3) != 0);
         pr  = ($urandom_range(0, 9) < 7);
         f   = ($urandom_range(0, 7) == 0) && !(v && m_terms.size() == FL - 1);
         chk_par = 1'($urandom_range(0, 1));
         cycle(sym, v, f, pr);
         n_vec++;
         if ({PAR_VALID, PAR, FLUSHED, CNT} !== exp_vec() || obs_ready !== exp_ready) begin
            n_err++;
            $display("FAIL random[%0d] got %b rdy=%b want %b rdy=%b", i,
                     {PAR_VALID, PAR, FLUSHED, CNT}, obs_ready, exp_vec(), exp_ready);
         end
`ifdef FRAME_PARITY_CHECK_EN
         n_vec++;
         if (PAR_ERR !== m_err) begin
            n_err++; $display("FAIL random_par_err[%0d] got %b want %b", i, PAR_ERR, m_err);
         end
`endif
      end
      chk_par = 1'b0;
      cycle(3'b000, 1'b0, 1'b0, 1'b1);
   endtask

`ifdef FRAME_PARITY_CHECK_EN
   task automatic test_check();
      logic [2:0] syms [4] = '{3'b000, 3'b111, 3'b100, 3'b100};
      logic       chk  [2] = '{1'b0, 1'b1};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) cycle(syms[i], 1'b1, 1'b0, 1'b0);
         chk_par = chk[k];
         cycle(3'b000, 1'b0, 1'b0, 1'b1);
         n_vec++;
         if (PAR_ERR !== ~chk[k]) begin
            n_err++; $display("FAIL par_err[%0d] got %b want %b", k, PAR_ERR, ~chk[k]);
         end
         cycle(3'b000, 1'b0, 1'b0, 1'b1);
         n_vec++;
         if (PAR_ERR !== 1'b0) begin
            n_err++; $display("FAIL par_err_pulse[%0d] got %b want 0", k, PAR_ERR);
         end
      end
      chk_par = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_frame();
      test_mixed();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef FRAME_PARITY_CHECK_EN
      test_check();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
